// File: rtl/pe_en_pkg.sv
// Shared types for the PE enable tracker: layer-type codes and tile FSM states.
package pe_en_pkg;

  localparam logic [1:0] POINTWISE = 2'b00;
  localparam logic [1:0] DEPTHWISE = 2'b01;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } pe_state_t;

endpackage

// File: rtl/pe_en_tracker_if.sv
// Scheduler/FIFO side bundle for pe_en_tracker; the tracker is the slave.
// No valid/ready pairs here: tile_start/tile_done are single-cycle pulses, pops are
// per-cycle strobes taken unconditionally, and every output is level-valid each cycle.
interface pe_en_tracker_if
  import pe_en_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int CNT_W = $clog2(COLS + 1)
);
  logic [1:0]           layer_type;
  logic [CNT_W-1:0]     col_limit;
  logic                 tile_start;
  logic                 tile_done;
  logic [ROWS-1:0]      ifmap_fifo_pop_en;
  logic [ROWS*COLS-1:0] pe_en;
  logic [ROWS-1:0]      row_full;
  logic                 fill_done;
  logic                 busy;
  logic                 overflow_err;
  pe_state_t            state_dbg;

  modport master (
    output layer_type, col_limit, tile_start, tile_done, ifmap_fifo_pop_en,
    input  pe_en, row_full, fill_done, busy, overflow_err, state_dbg
  );

  modport slave (
    input  layer_type, col_limit, tile_start, tile_done, ifmap_fifo_pop_en,
    output pe_en, row_full, fill_done, busy, overflow_err, state_dbg
  );
endinterface

// File: rtl/pe_row_counter.sv
// One PE row: saturating pop counter and thermometer decode onto the row's columns.
module pe_row_counter #(
  parameter int COLS  = 32,
  parameter int CNT_W = $clog2(COLS + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [CNT_W-1:0] lim,
  input  logic             mode_en,
  output logic [COLS-1:0]  en,
  output logic             full,
  output logic             ovf
);
  logic [CNT_W-1:0] cnt_q;

  assign full = (cnt_q == lim);
  assign ovf  = inc && full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clear) begin
      cnt_q <= '0;
    end else if (inc && !full) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  for (genvar c = 0; c < COLS; c++) begin : g_col
    assign en[c] = mode_en && (cnt_q > CNT_W'(c));
  end
endmodule

// File: rtl/pe_en_tracker.sv
// Per-tile PE enable generator: tile FSM, per-tile limit/mode latches, ROWS row counters.
module pe_en_tracker
  import pe_en_pkg::*;
#(
  parameter int ROWS  = 32,
  parameter int COLS  = 32,
  parameter int CNT_W = $clog2(COLS + 1)
) (
  input logic           clk,
  input logic           rst_n,
  pe_en_tracker_if.slave bus
);
  pe_state_t        state_q, state_d;
  logic [CNT_W-1:0] lim_q, lim_clamped;
  logic [1:0]       mode_q;
  logic             ovf_q;
  logic             active, mode_en, cnt_clear;
  logic [ROWS-1:0]  pop_live, full_raw, ovf_row;

  assign active      = (state_q != IDLE);
  assign mode_en     = active && (mode_q == POINTWISE || mode_q == DEPTHWISE);
  assign cnt_clear   = bus.tile_start || bus.tile_done;
  // Pops in the tile_start cycle belong to no tile; pops in IDLE are dropped.
  assign pop_live    = bus.ifmap_fifo_pop_en & {ROWS{active && !bus.tile_start}};
  assign lim_clamped = (bus.col_limit > CNT_W'(COLS)) ? CNT_W'(COLS) : bus.col_limit;

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    pe_row_counter #(.COLS(COLS), .CNT_W(CNT_W)) u_row (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (cnt_clear),
      .inc     (pop_live[r]),
      .lim     (lim_q),
      .mode_en (mode_en),
      .en      (bus.pe_en[r*COLS +: COLS]),
      .full    (full_raw[r]),
      .ovf     (ovf_row[r])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lim_q   <= '0;
      mode_q  <= POINTWISE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (bus.tile_start) begin
        lim_q  <= lim_clamped;
        mode_q <= bus.layer_type;
        ovf_q  <= 1'b0;
      end else if (|ovf_row) begin
        ovf_q <= 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.tile_start) begin
      state_d = FILL;
    end else if (bus.tile_done) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        FILL:    if (&full_raw) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = IDLE;
      endcase
    end
  end

  assign bus.row_full     = active ? full_raw : '0;
  assign bus.fill_done    = (state_q == RUN);
  assign bus.busy         = active;
  assign bus.overflow_err = ovf_q;
  assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_pe_en_tracker.sv
// Directed bench for pe_en_tracker: one task per scenario, hand-computed expectations.
module tb_pe_en_tracker;
  import pe_en_pkg::*;

  localparam int ROWS  = 32;
  localparam int COLS  = 32;
  localparam int CNT_W = $clog2(COLS + 1);
  localparam int W     = ROWS * COLS;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;
  logic [3:0] exp_q[$];

  pe_en_tracker_if #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) bus ();

  pe_en_tracker #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Driver tasks
  task automatic drive_idle();
    bus.tile_start        = 1'b0;
    bus.tile_done         = 1'b0;
    bus.ifmap_fifo_pop_en = '0;
  endtask

  task automatic start_tile(input logic [CNT_W-1:0] lim, input logic [1:0] mode);
    bus.col_limit  = lim;
    bus.layer_type = mode;
    bus.tile_start = 1'b1;
    tick();
    bus.tile_start = 1'b0;
  endtask

  task automatic end_tile();
    bus.tile_done = 1'b1;
    tick();
    bus.tile_done = 1'b0;
  endtask

  task automatic test_reset();
    drive_idle();
    bus.col_limit  = '0;
    bus.layer_type = 2'b00;
    rst_n = 1'b0;
    tick();
    tick();
    n_cmp++;
    if (bus.pe_en !== '0 || bus.row_full !== '0 || bus.fill_done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.overflow_err !== 1'b0 || bus.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b fill=%b ovf=%b row_full=%h state=%0d, need all zero/IDLE",
               bus.busy, bus.fill_done, bus.overflow_err, bus.row_full, bus.state_dbg);
    end
    rst_n = 1'b1;
    // Pops while idle must not leave anything behind
    bus.ifmap_fifo_pop_en = '1;
    tick();
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pe_en !== '0 || bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_pop: busy=%b ovf=%b pe_en_nonzero=%b, need 0/0/0",
               bus.busy, bus.overflow_err, |bus.pe_en);
    end
  endtask

  task automatic test_row0_fill();
    logic [3:0] exp;
    exp_q = {4'b0001, 4'b0011, 4'b0111, 4'b1111};
    start_tile(CNT_W'(4), POINTWISE);
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.pe_en !== '0) begin
      n_fail++;
      $display("FAIL row0_start: busy=%b pe_en_nonzero=%b, need 1/0", bus.busy, |bus.pe_en);
    end
    for (int i = 0; i < 4; i++) begin
      bus.ifmap_fifo_pop_en = 32'h1;
      tick();
      exp = exp_q.pop_front();
      n_cmp++;
      if (bus.pe_en[3:0] !== exp || bus.pe_en[W-1:4] !== '0) begin
        n_fail++;
        $display("FAIL row0_thermo[%0d]: pe_en[3:0]=%b upper_nonzero=%b, need %b/0",
                 i, bus.pe_en[3:0], |bus.pe_en[W-1:4], exp);
      end
    end
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.row_full !== 32'h1 || bus.fill_done !== 1'b0 || bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL row0_full: row_full=%h fill=%b ovf=%b, need 00000001/0/0",
               bus.row_full, bus.fill_done, bus.overflow_err);
    end
    end_tile();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pe_en !== '0 || bus.row_full !== '0) begin
      n_fail++;
      $display("FAIL row0_done: busy=%b pe_en_nonzero=%b row_full=%h, need 0/0/0",
               bus.busy, |bus.pe_en, bus.row_full);
    end
  endtask

  task automatic test_all_rows();
    start_tile(CNT_W'(32), DEPTHWISE);
    bus.ifmap_fifo_pop_en = '1;
    for (int i = 0; i < 31; i++) tick();
    n_cmp++;
    if (bus.row_full !== '0 || bus.fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL all_31: row_full=%h fill=%b, need 0/0", bus.row_full, bus.fill_done);
    end
    tick();
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.row_full !== '1 || bus.fill_done !== 1'b0 || bus.pe_en !== {W{1'b1}}) begin
      n_fail++;
      $display("FAIL all_32: row_full=%h fill=%b pe_en_all=%b, need ffffffff/0/1",
               bus.row_full, bus.fill_done, &bus.pe_en);
    end
    tick();
    n_cmp++;
    if (bus.fill_done !== 1'b1 || bus.state_dbg !== RUN || bus.pe_en !== {W{1'b1}}) begin
      n_fail++;
      $display("FAIL all_run: fill=%b state=%0d pe_en_all=%b, need 1/RUN/1",
               bus.fill_done, bus.state_dbg, &bus.pe_en);
    end
    end_tile();
  endtask

  task automatic test_overflow();
    logic [W-1:0] exp;
    exp = '0;
    exp[5*COLS +: 2] = 2'b11;
    start_tile(CNT_W'(2), POINTWISE);
    for (int i = 0; i < 2; i++) begin
      bus.ifmap_fifo_pop_en = 32'h20;
      tick();
    end
    n_cmp++;
    if (bus.overflow_err !== 1'b0 || bus.row_full[5] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_pre: ovf=%b row_full5=%b, need 0/1", bus.overflow_err, bus.row_full[5]);
    end
    tick();
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.overflow_err !== 1'b1 || bus.pe_en !== exp) begin
      n_fail++;
      $display("FAIL ovf_post: ovf=%b row5=%h, need 1/00000003 (rest zero)",
               bus.overflow_err, bus.pe_en[5*COLS +: COLS]);
    end
    tick();
    n_cmp++;
    if (bus.overflow_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: ovf=%b, need 1", bus.overflow_err);
    end
    start_tile(CNT_W'(2), POINTWISE);
    n_cmp++;
    if (bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: ovf=%b, need 0", bus.overflow_err);
    end
    end_tile();
  endtask

  task automatic test_other_mode();
    start_tile(CNT_W'(3), 2'b10);
    for (int i = 0; i < 3; i++) begin
      bus.ifmap_fifo_pop_en = 32'h2;
      tick();
    end
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.pe_en !== '0 || bus.row_full !== 32'h2) begin
      n_fail++;
      $display("FAIL mode_other: pe_en_nonzero=%b row_full=%h, need 0/00000002",
               |bus.pe_en, bus.row_full);
    end
    end_tile();
  endtask

  task automatic test_zero_limit_and_restart();
    start_tile(CNT_W'(0), POINTWISE);
    n_cmp++;
    if (bus.state_dbg !== FILL || bus.row_full !== '1 || bus.fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_fill: state=%0d row_full=%h fill=%b, need FILL/ffffffff/0",
               bus.state_dbg, bus.row_full, bus.fill_done);
    end
    tick();
    n_cmp++;
    if (bus.fill_done !== 1'b1 || bus.pe_en !== '0) begin
      n_fail++;
      $display("FAIL zero_run: fill=%b pe_en_nonzero=%b, need 1/0", bus.fill_done, |bus.pe_en);
    end
    // tile_start wins over tile_done in the same cycle
    bus.col_limit  = CNT_W'(4);
    bus.tile_start = 1'b1;
    bus.tile_done  = 1'b1;
    tick();
    drive_idle();
    n_cmp++;
    if (bus.state_dbg !== FILL || bus.busy !== 1'b1 || bus.pe_en !== '0 ||
        bus.row_full !== '0 || bus.fill_done !== 1'b0) begin
      n_fail++;
      $display("FAIL start_over_done: state=%0d busy=%b row_full=%h fill=%b, need FILL/1/0/0",
               bus.state_dbg, bus.busy, bus.row_full, bus.fill_done);
    end
    end_tile();
  endtask

  task automatic test_clamp();
    // Pop held through the tile_start cycle must be discarded
    bus.ifmap_fifo_pop_en = 32'h4;
    start_tile(CNT_W'(40), POINTWISE);
    for (int i = 0; i < 31; i++) tick();
    n_cmp++;
    if (bus.row_full[2] !== 1'b0 || bus.pe_en[2*COLS +: COLS] !== 32'h7fff_ffff) begin
      n_fail++;
      $display("FAIL clamp_31: row_full2=%b row2=%h, need 0/7fffffff",
               bus.row_full[2], bus.pe_en[2*COLS +: COLS]);
    end
    tick();
    bus.ifmap_fifo_pop_en = '0;
    n_cmp++;
    if (bus.row_full !== 32'h4 || bus.pe_en[2*COLS +: COLS] !== 32'hffff_ffff ||
        bus.overflow_err !== 1'b0) begin
      n_fail++;
      $display("FAIL clamp_32: row_full=%h row2=%h ovf=%b, need 00000004/ffffffff/0",
               bus.row_full, bus.pe_en[2*COLS +: COLS], bus.overflow_err);
    end
  endtask

  task automatic test_reset_mid_tile();
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.pe_en !== '0 || bus.row_full !== '0) begin
      n_fail++;
      $display("FAIL async_reset: busy=%b pe_en_nonzero=%b row_full=%h, need 0/0/0",
               bus.busy, |bus.pe_en, bus.row_full);
    end
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.state_dbg !== IDLE) begin
      n_fail++;
      $display("FAIL post_reset_idle: busy=%b state=%0d, need 0/IDLE", bus.busy, bus.state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_row0_fill();
    test_all_rows();
    test_overflow();
    test_other_mode();
    test_zero_limit_and_restart();
    test_clamp();
    test_reset_mid_tile();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/pe_en_tracker.md
# pe_en_tracker

Parametrised per-tile PE enable generator for the token engine's PE array. Counts ifmap FIFO pops per PE row, turns each row's count into a thermometer enable across that row's columns, and runs a small tile state machine. The state machine clears counts at every tile start, saturates at a per-tile column limit, flags extra pops, and reports when every row has filled. It sits between the ifmap FIFO pop logic and the PE array enable inputs, and is controlled by the tile scheduler.

## Interface
- ROWS, 32: PE array rows; one ifmap FIFO per row.
- COLS, 32: PE array columns.
- CNT_W, $clog2(COLS+1): width of the per-row count and the column limit.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- layer_type  in  2  layer type (POINTWISE / DEPTHWISE / other); sampled at tile_start.
- col_limit  in  CNT_W  active columns for this tile; sampled at tile_start.
- tile_start  in  1  one-cycle pulse; clears the counts and begins a fill.
- tile_done  in  1  one-cycle pulse; ends the tile and returns to IDLE.
- ifmap_fifo_pop_en  in  ROWS  per-row pop strobe.
- pe_en  out  ROWS*COLS  enable for PE[r][c] at bit r*COLS+c.
- row_full  out  ROWS  row count equals the latched limit.
- fill_done  out  1  high while in RUN.
- busy  out  1  high when state is not IDLE.
- overflow_err  out  1  sticky; a pop arrived on a row that was already full.

## Operation
- FSM states: IDLE, FILL, RUN; reset state IDLE.
- IDLE -> FILL on tile_start.
- FILL -> RUN when every row_full bit is 1.
- Any state -> IDLE on tile_done.
- tile_start in any state, including FILL and RUN, re-enters FILL. tile_start has priority over tile_done in the same cycle.
- At tile_start:
  - lim_q <= min(col_limit, COLS).
  - mode_q <= layer_type.
  - All counts cleared to 0.
  - overflow_err cleared.
  - Pops arriving in the tile_start cycle are discarded.
- In FILL, for each row r:
  - pop with cnt[r] < lim_q: cnt[r] increments by 1.
  - pop with cnt[r] == lim_q: count held, overflow_err set.
- In IDLE and RUN, pops do not change counts. A pop in RUN sets overflow_err. A pop in IDLE is ignored.
- row_full[r] = (cnt[r] == lim_q) in FILL and RUN; 0 in IDLE.
- pe_en[r*COLS+c] = (cnt[r] > c), only when state != IDLE and mode_q is POINTWISE or DEPTHWISE. Any other mode_q forces all enables to 0 while the counts still run.
- lim_q == 0: all rows are full immediately, FILL lasts exactly one cycle, pe_en stays all-zero.
- tile_done leaves IDLE with counts cleared.

## Timing
- Reset values: counts 0, state IDLE, pe_en 0, row_full 0, fill_done 0, busy 0, overflow_err 0.
- Counts, state and overflow_err are registered. pe_en, row_full, fill_done and busy are combinational from registers; there is no combinational path from any input to any output.
- Latency:
  - Pop at cycle t: the matching pe_en bit rises in cycle t+1.
  - tile_start at t: busy=1 and counts=0 from t+1.
  - Last filling pop at t: cnt updates at t+1, the FSM enters RUN at t+2, and fill_done=1 from t+2.
- Reset asserted mid-tile: all state clears asynchronously. After release the block idles until tile_start.
- Simultaneous pops on all rows are handled in parallel; there is no arbitration.

## Structure
- Shared package pe_en_pkg holds:
  - layer_type localparams: POINTWISE=2'b00, DEPTHWISE=2'b01.
  - State enum typedef with IDLE, FILL, RUN.
- One natural sub-module, pe_row_counter: the per-row saturating counter plus thermometer decoder, generated ROWS times. Inputs: clear, inc, lim, mode_en. Outputs: COLS-bit enable, full, ovf.
- The top level holds the FSM, the lim_q/mode_q latches and the OR-reduce of the per-row ovf outputs.

## Test plan
- Reset, then tile_start with col_limit=4, mode POINTWISE, one pop per cycle on row 0 only -> pe_en[3:0] goes 0001, 0011, 0111, 1111 one cycle after each pop; row_full[0]=1; fill_done stays 0.
- ROWS=32, COLS=32, limit 32, all rows popping every cycle -> fill_done rises 2 cycles after the 32nd pop; pe_en is all ones.
- Limit 2, three pops on row 5 -> cnt[5]=2; overflow_err=1 from the cycle after the third pop; pe_en bits 5*COLS+{0,1} are 1.
- layer_type=2'b10 with pops -> pe_en stays all-zero, and row_full still tracks the counts.
- In RUN, pulse tile_start and tile_done in the same cycle -> next cycle FILL, counts 0, pe_en 0, busy 1.
- col_limit=0 -> FILL for one cycle, then RUN with pe_en 0. Separately, col_limit=40 with COLS=32 -> limit clamped to 32.
